if_id_pipe_reg: RTL and testbench



---
 rtl/if_id_pkg.sv | 28 ++
 rtl/if_id_pipe_reg.sv | 107 ++++++++++
 tb/tb_if_id_pipe_reg.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
package if_id_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned PC_W_DEF = 32;
  localparam logic [XLEN_DEF-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } if_id_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] ins;
    logic [PC_W_DEF-1:0] pc;
    logic                fault;
  } if_id_entry_t;

  function automatic logic [1:0] occ_of(input if_id_state_t s);
    case (s)
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready on both sides, stall and flush.
// Define IF_ID_SKID_EN to build the two-entry skid variant with a registered if_ready.
module if_id_pipe_reg #(
  parameter int unsigned          XLEN     = if_id_pkg::XLEN_DEF,
  parameter int unsigned          PC_W     = if_id_pkg::PC_W_DEF,
  parameter logic [XLEN-1:0]      NOP_INSN = if_id_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_ins,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_fault,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_ins,
  output logic [PC_W-1:0] id_pc,
  output logic            id_fault,
  output logic [1:0]      occupancy
);

  import if_id_pkg::*;

  if_id_state_t state_q;
  if_id_entry_t main_q;
  if_id_entry_t in_d;
  logic         in_xfer;
  logic         out_xfer;

  always_comb begin
    in_d       = '0;
    in_d.ins   = if_ins;
    in_d.pc    = if_pc;
    in_d.fault = if_fault;
  end

`ifdef IF_ID_SKID_EN
  if_id_entry_t skid_q;

  // Depends only on state_q and rst, so nothing from id_ready reaches if_ready.
  assign if_ready = !rst && (state_q != TWO);
`else
  assign if_ready = !rst && ((state_q == EMPTY) || id_ready);
`endif

  assign id_valid = (state_q != EMPTY);
  assign in_xfer  = if_valid && if_ready;
  assign out_xfer = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
`ifdef IF_ID_SKID_EN
      skid_q  <= '0;
`endif
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q  <= in_d;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_d;
          end else if (out_xfer) begin
            state_q <= EMPTY;
`ifdef IF_ID_SKID_EN
          end else if (in_xfer) begin
            skid_q  <= in_d;
            state_q <= TWO;
`endif
          end
        end
`ifdef IF_ID_SKID_EN
        TWO: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
`endif
        default: state_q <= EMPTY;
      endcase
    end
  end

  always_comb begin
    id_ins   = NOP_INSN;
    id_pc    = '0;
    id_fault = 1'b0;
    if (id_valid) begin
      id_ins   = main_q.ins;
      id_pc    = main_q.pc;
      id_fault = main_q.fault;
    end
  end

  assign occupancy = occ_of(state_q);

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: a FIFO model of held entries predicts outputs.
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_ins = '0;
  logic [31:0] if_pc = '0;
  logic        if_fault = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_ins;
  logic [31:0] id_pc;
  logic        id_fault;
  logic [1:0]  occupancy;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  ent_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   first_cycle = 1'b1;

  if_id_pipe_reg #(
    .XLEN(32),
    .PC_W(32),
    .NOP_INSN(32'h0000_0013)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_ins(if_ins), .if_pc(if_pc), .if_fault(if_fault),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_ins(id_ins), .id_pc(id_pc), .id_fault(id_fault),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive after the edge, check held state, then record acceptance.
  task automatic cyc(input logic r, input logic v, input logic [31:0] ins,
                     input logic [31:0] pc, input logic f, input logic rdy, input logic fl);
    logic exp_rdy;
    int   n;
    @(posedge clk);
    #1;
    rst = r; if_valid = v; if_ins = ins; if_pc = pc; if_fault = f;
    id_ready = rdy; flush = fl;
    #1;
    n = sb.size();
    if (r)            exp_rdy = 1'b0;
    else if (CAP == 2) exp_rdy = (n < 2);
    else              exp_rdy = (n == 0) || rdy;
    check("if_ready", {31'd0, if_ready}, {31'd0, exp_rdy});
    if (!first_cycle) begin
      check("id_valid", {31'd0, id_valid}, {31'd0, n != 0});
      check("occupancy", {30'd0, occupancy}, n);
      if (n != 0) begin
        check("id_pc", id_pc, sb[0].pc);
        check("id_ins", id_ins, sb[0].ins);
        check("id_fault", {31'd0, id_fault}, {31'd0, sb[0].fault});
      end else begin
        check("id_ins_nop", id_ins, NOP);
        check("id_pc_zero", id_pc, 32'd0);
        check("id_fault_zero", {31'd0, id_fault}, 32'd0);
      end
    end
    first_cycle = 1'b0;
    #2;
    if (!r && !fl && v && exp_rdy) sb.push_back('{ins: ins, pc: pc, fault: f});
  endtask

  // Monitor: every delivered entry must be the oldest one the model holds.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (id_valid && id_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out_pc", id_pc, 32'hFFFF_FFFF);
        end else begin
          ent_t e;
          e = sb.pop_front();
          check("out_pc", id_pc, e.pc);
          check("out_ins", id_ins, e.ins);
          check("out_fault", {31'd0, id_fault}, {31'd0, e.fault});
        end
      end
      if (flush) sb.delete();
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h1111_0000, 32'h50, 0, 0, 0);

    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hA000_0000 + i, 32'h100 + 4 * i, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    cyc(0, 1, 32'hB000_0000, 32'h200, 0, 0, 0);
    cyc(0, 1, 32'hB000_0004, 32'h204, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    cyc(0, 1, 32'hC000_0000, 32'h210, 0, 0, 0);
    cyc(0, 1, 32'hC000_0004, 32'h214, 0, 0, 0);
    cyc(0, 1, 32'hC000_0008, 32'h300, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    cyc(0, 1, 32'hDEAD_BEEF, 32'h400, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 500; i++) begin
      cyc(0, 1'($urandom_range(0, 3) != 0), $urandom, {$urandom_range(0, 1023), 2'b00},
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
